// File: rtl/aes_ctrl_pkg.sv
// ============================================================================
// Module  : aes_ctrl_pkg
// Brief   : Shared state type and constants for the execution controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_RUN      = 3'd1,
        ST_DBG_WAIT = 3'd2,
        ST_DBG_STEP = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    localparam int c_STEP_CNT_W = 16;

    function automatic logic cpu_active(input state_t s);
        return (s == ST_RUN) || (s == ST_DBG_STEP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/debouncer.sv
// ============================================================================
// Module  : debouncer
// Brief   : 2-flop synchronizer plus stable-count debouncer with edge pulses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module debouncer #(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int             c_CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_rise;
    logic            r_fall;
    logic [c_CW-1:0] r_cnt;

    // Edge pulses are registered alongside the level flip so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= RESET_VAL;
            r_sync2 <= RESET_VAL;
            r_level <= RESET_VAL;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == c_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    r_rise  <= r_sync2;
                    r_fall  <= ~r_sync2;
                end else begin
                    r_cnt <= r_cnt + c_CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/exec_controller.sv
// ============================================================================
// Module  : exec_controller
// Brief   : Power/debug/step sequencing FSM producing the processor clock enable.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_controller
    import aes_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STEP_CYCLES     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pwr,
    input  logic                    dbg,
    input  logic                    stp,
    input  logic                    halt,
    output logic                    cpu_en,
    output logic [2:0]              state_o,
    output logic [c_STEP_CNT_W-1:0] step_cnt
);

    localparam int              c_SCW       = $clog2(STEP_CYCLES + 1);
    localparam logic [c_SCW-1:0] c_STEP_LAST = c_SCW'(STEP_CYCLES - 1);

    logic w_pwr_level, w_pwr_rise, w_pwr_fall;
    logic w_dbg_level, w_dbg_rise, w_dbg_fall;
    logic w_stp_level, w_stp_rise, w_stp_fall;
    logic w_unused;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_pwr (
        .clk(clk), .rst(rst), .i_raw(pwr),
        .o_level(w_pwr_level), .o_rise(w_pwr_rise), .o_fall(w_pwr_fall)
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_dbg (
        .clk(clk), .rst(rst), .i_raw(dbg),
        .o_level(w_dbg_level), .o_rise(w_dbg_rise), .o_fall(w_dbg_fall)
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_stp (
        .clk(clk), .rst(rst), .i_raw(stp),
        .o_level(w_stp_level), .o_rise(w_stp_rise), .o_fall(w_stp_fall)
    );

    assign w_unused = ^{w_pwr_level, w_pwr_rise, w_dbg_rise, w_dbg_fall,
                        w_stp_level, w_stp_fall};

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_step_done;
    logic                    r_cpu_en;
    logic [c_SCW-1:0]        r_step_cyc;
    logic [c_STEP_CNT_W-1:0] r_step_cnt;

    always_comb begin
        w_next      = r_state;
        w_step_done = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (w_pwr_fall) begin
                    w_next = w_dbg_level ? ST_DBG_WAIT : ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    w_next = ST_HALT;
                end else if (w_dbg_level) begin
                    w_next = ST_DBG_WAIT;
                end
            end
            ST_DBG_WAIT: begin
                if (halt) begin
                    w_next = ST_HALT;
                end else if (!w_dbg_level) begin
                    w_next = ST_RUN;
                end else if (w_stp_rise) begin
                    w_next = ST_DBG_STEP;
                end
            end
            // A step always runs to completion; halt is honoured from DBG_WAIT.
            ST_DBG_STEP: begin
                if (r_step_cyc == c_STEP_LAST) begin
                    w_next      = ST_DBG_WAIT;
                    w_step_done = 1'b1;
                end
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_OFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_OFF;
            r_cpu_en   <= 1'b0;
            r_step_cyc <= '0;
            r_step_cnt <= '0;
        end else begin
            r_state  <= w_next;
            r_cpu_en <= cpu_active(w_next);
            if ((r_state == ST_DBG_STEP) && !w_step_done) begin
                r_step_cyc <= r_step_cyc + c_SCW'(1);
            end else begin
                r_step_cyc <= '0;
            end
            if (w_step_done && (r_step_cnt != '1)) begin
                r_step_cnt <= r_step_cnt + c_STEP_CNT_W'(1);
            end
        end
    end

    assign cpu_en   = r_cpu_en;
    assign state_o  = r_state;
    assign step_cnt = r_step_cnt;

endmodule

`default_nettype wire

// File: tb/tb_exec_controller.sv
// ============================================================================
// Module  : tb_exec_controller
// Brief   : Directed bench with a history-based behavioural model of exec_controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exec_controller;

    localparam int N  = 4;
    localparam int SC = 1;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        pwr  = 1'b1;
    logic        dbg  = 1'b0;
    logic        stp  = 1'b0;
    logic        halt = 1'b0;
    logic        cpu_en;
    logic [2:0]  state_o;
    logic [15:0] step_cnt;

    exec_controller #(.DEBOUNCE_CYCLES(N), .STEP_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .pwr(pwr), .dbg(dbg), .stp(stp), .halt(halt),
        .cpu_en(cpu_en), .state_o(state_o), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else begin
            fails++;
            $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)", nm, $time, act, act, exp, exp);
        end
    endtask

    // Model: raw samples per input (0=pwr,1=dbg,2=stp); index 0 newest.
    bit h [3][0:N+1];
    bit md[3];
    bit m_fall, m_rise;
    int m_st, m_sc, m_cnt;
    bit ld_req = 1'b0;
    int ld_val = 0;

    function automatic bit rvv(input int i);
        return (i == 0);
    endfunction

    function automatic bit raw_in(input int i);
        return (i == 0) ? pwr : ((i == 1) ? dbg : stp);
    endfunction

    always @(posedge clk) begin
        bit nh[3][0:N+1];
        bit nd[3];
        bit nf, nr, allx;
        int st, sc, cnt;
        nh  = h;
        nd  = md;
        st  = m_st;
        sc  = m_sc;
        cnt = ld_req ? ld_val : m_cnt;
        nf  = 1'b0;
        nr  = 1'b0;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int k = 0; k <= N + 1; k++) nh[i][k] = rvv(i);
                nd[i] = rvv(i);
            end
            st = 0; sc = 0; cnt = 0;
        end else begin
            case (st)
                0: if (m_fall) st = md[1] ? 2 : 1;
                1: if (halt) st = 4; else if (md[1]) st = 2;
                2: begin
                    if (halt) st = 4;
                    else if (!md[1]) st = 1;
                    else if (m_rise) begin st = 3; sc = 0; end
                end
                3: begin
                    sc = sc + 1;
                    if (sc == SC) begin
                        st = 2;
                        if (cnt != 16'hFFFF) cnt = cnt + 1;
                    end
                end
                default: st = 4;
            endcase
            // A level flips once the last N synchronized samples all disagree with it.
            for (int i = 0; i < 3; i++) begin
                allx = 1'b1;
                for (int k = 1; k <= N; k++) if (h[i][k] == md[i]) allx = 1'b0;
                if (allx) begin
                    nd[i] = ~md[i];
                    if (i == 0 && !nd[i]) nf = 1'b1;
                    if (i == 2 && nd[i])  nr = 1'b1;
                end
                for (int k = N + 1; k >= 1; k--) nh[i][k] = h[i][k-1];
                nh[i][0] = raw_in(i);
            end
        end
        h      <= nh;
        md     <= nd;
        m_fall <= nf;
        m_rise <= nr;
        m_st   <= st;
        m_sc   <= sc;
        m_cnt  <= cnt;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("state_o", int'(state_o), m_st);
            chk("cpu_en", int'(cpu_en), (m_st == 1 || m_st == 3) ? 1 : 0);
            chk("step_cnt", int'(step_cnt), m_cnt);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input string nm, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (cpu_en) seen = 1'b1;
        end
        if (!seen) chk(nm, 0, 1);
    endtask

    task automatic press(output int pulses);
        pulses = 0;
        stp = 1'b1;
        for (int i = 0; i < 8; i++) begin cyc(1); if (cpu_en) pulses++; end
        stp = 1'b0;
        for (int i = 0; i < 8; i++) begin cyc(1); if (cpu_en) pulses++; end
    endtask

    initial begin
        int p, tot;
        rst = 1'b0; pwr = 1'b1; dbg = 1'b0; stp = 1'b0; halt = 1'b0;
        cyc(3);
        mon_en = 1'b1;
        chk("rst_state", int'(state_o), 0);
        chk("rst_cpu_en", int'(cpu_en), 0);
        chk("rst_step_cnt", int'(step_cnt), 0);
        rst = 1'b1;
        cyc(20);

        pwr = 1'b0; cyc(3); pwr = 1'b1;
        cyc(12);
        chk("glitch_state", int'(state_o), 0);
        chk("glitch_cpu_en", int'(cpu_en), 0);

        pwr = 1'b0;
        cyc(6);
        chk("pre_run_state", int'(state_o), 0);
        cyc(1);
        chk("run_state_t7", int'(state_o), 1);
        chk("run_cpu_en_t7", int'(cpu_en), 1);

        pwr = 1'b1; cyc(10); pwr = 1'b0; cyc(10);
        chk("pwr_latched", int'(state_o), 1);

        dbg = 1'b1;
        cyc(7);
        chk("dbg_wait_state", int'(state_o), 2);

        tot = 0;
        for (int i = 0; i < 3; i++) begin press(p); tot += p; end
        chk("three_step_pulses", tot, 3);
        chk("three_step_cnt", int'(step_cnt), 3);
        chk("three_step_state", int'(state_o), 2);

        @(negedge clk); #1;
        force dut.r_step_cnt = 16'hFFFE;
        ld_val = 16'hFFFE; ld_req = 1'b1;
        #1 release dut.r_step_cnt;
        @(posedge clk); #1 ld_req = 1'b0;
        press(p);
        chk("cnt_reach_max", int'(step_cnt), 16'hFFFF);
        press(p);
        chk("cnt_saturate", int'(step_cnt), 16'hFFFF);
        chk("sat_step_pulse", p, 1);

        stp = 1'b1;
        wait_en("timeout_step_for_reset", 20);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; stp = 1'b0;
        chk("midstep_rst_state", int'(state_o), 0);
        chk("midstep_rst_cpu_en", int'(cpu_en), 0);
        chk("midstep_rst_cnt", int'(step_cnt), 0);
        cyc(15);
        chk("repower_dbg_wait", int'(state_o), 2);

        stp = 1'b1;
        wait_en("timeout_step_for_halt", 20);
        halt = 1'b1;
        @(posedge clk); #1;
        chk("halt_step_done_state", int'(state_o), 2);
        chk("halt_step_done_cnt", int'(step_cnt), 1);
        cyc(1);
        chk("halt_state", int'(state_o), 4);
        chk("halt_cpu_en", int'(cpu_en), 0);
        stp = 1'b0; halt = 1'b0; dbg = 1'b0;
        cyc(20);
        chk("halt_sticky", int'(state_o), 4);

        rst = 1'b0; cyc(2); rst = 1'b1;
        chk("halt_rst_state", int'(state_o), 0);
        cyc(3);
        mon_en = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule

`default_nettype wire
